// File: rtl/metronome_beat_scheduler_if.sv
// Control/status bundle between the metronome scheduler and its host:
// run/period/accent inputs, beat and tone outputs.
interface metronome_beat_scheduler_if;
    logic        run;
    logic [26:0] beat_period;
    logic [14:0] accent_mask;
    logic [3:0]  beat_num;
    logic        beat_tick;
    logic        tone_en;
    logic        speaker_out;
    logic        count_in;

    modport master (
        output run, beat_period, accent_mask,
        input  beat_num, beat_tick, tone_en, speaker_out, count_in
    );

    modport slave (
        input  run, beat_period, accent_mask,
        output beat_num, beat_tick, tone_en, speaker_out, count_in
    );
endinterface

// File: rtl/metronome_beat_scheduler.sv
// Metronome sequencer: one beat per period, a square-wave beep at the start of
// each beat, accent/normal pitch per beat. Optional count-in bar: COUNT_IN_EN.
module metronome_beat_scheduler #(
    parameter int BEATS_PER_BAR = 8,
    parameter int BEEP_CYCLES   = 5400000,
    parameter int ACCENT_HALF   = 32507,
    parameter int NORMAL_HALF   = 48704
) (
    input logic                        clk,
    input logic                        rst,
    metronome_beat_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BEEP, GAP} state_t;

    localparam int HALF_MAX = (ACCENT_HALF > NORMAL_HALF) ? ACCENT_HALF : NORMAL_HALF;
    localparam int HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    localparam logic [HALF_W-1:0] ACC_LAST   = HALF_W'(ACCENT_HALF - 1);
    localparam logic [HALF_W-1:0] NRM_LAST   = HALF_W'(NORMAL_HALF - 1);
    localparam logic [26:0]       BEEP_LAST  = 27'(BEEP_CYCLES - 1);
    localparam logic [26:0]       MIN_PERIOD = 27'(BEEP_CYCLES + 2);
    localparam logic [3:0]        LAST_BEAT  = 4'(BEATS_PER_BAR);

`ifdef COUNT_IN_EN
    localparam logic COUNT_IN_ON = 1'b1;
`else
    localparam logic COUNT_IN_ON = 1'b0;
`endif

    // A period shorter than the beep plus a gap would swallow the gap entirely.
    function automatic logic [26:0] clamp_period(input logic [26:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    state_t            state_q, state_d;
    logic [26:0]       beat_cnt_q, beat_cnt_d;
    logic [26:0]       eff_period_q, eff_period_d;
    logic [3:0]        beat_num_q, beat_num_d;
    logic              beat_tick_q, beat_tick_d;
    logic              tone_en_q, tone_en_d;
    logic              speaker_q, speaker_d;
    logic              count_in_q, count_in_d;
    logic              accent_q, accent_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;

    logic              start_beat;
    logic              new_bar;
    logic [3:0]        mask_idx;
    logic [HALF_W-1:0] half_last;

    assign half_last = accent_q ? ACC_LAST : NRM_LAST;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        eff_period_d = eff_period_q;
        beat_num_d   = beat_num_q;
        beat_tick_d  = 1'b0;
        speaker_d    = speaker_q;
        count_in_d   = count_in_q;
        accent_d     = accent_q;
        half_cnt_d   = half_cnt_q;
        start_beat   = 1'b0;
        new_bar      = 1'b0;
        mask_idx     = 4'd0;

        if (!bus.run) begin
            // Abort wins over everything and wipes the whole schedule.
            state_d      = IDLE;
            beat_cnt_d   = '0;
            eff_period_d = '0;
            beat_num_d   = '0;
            speaker_d    = 1'b0;
            count_in_d   = 1'b0;
            accent_d     = 1'b0;
            half_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    start_beat = 1'b1;
                    new_bar    = 1'b1;
                    beat_num_d = 4'd1;
                    count_in_d = COUNT_IN_ON;
                end
                BEEP: begin
                    beat_cnt_d = beat_cnt_q + 27'd1;
                    if (beat_cnt_q == BEEP_LAST) begin
                        state_d    = GAP;
                        speaker_d  = 1'b0;
                        half_cnt_d = '0;
                    end else if (half_cnt_q == half_last) begin
                        speaker_d  = ~speaker_q;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (beat_cnt_q == eff_period_q - 27'd1) begin
                        start_beat = 1'b1;
                        if (beat_num_q == LAST_BEAT) begin
                            beat_num_d = 4'd1;
                            new_bar    = 1'b1;
                            count_in_d = 1'b0;
                        end else begin
                            beat_num_d = beat_num_q + 4'd1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 27'd1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (start_beat) begin
                state_d     = BEEP;
                beat_cnt_d  = '0;
                beat_tick_d = 1'b1;
                speaker_d   = 1'b1;
                half_cnt_d  = '0;
                mask_idx    = beat_num_d - 4'd1;
                accent_d    = count_in_d | bus.accent_mask[mask_idx];
            end

            // Period only takes effect on bar boundaries so a bar never stretches mid-way.
            if (new_bar) begin
                eff_period_d = clamp_period(bus.beat_period);
            end
        end

        tone_en_d = (state_d == BEEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            eff_period_q <= '0;
            beat_num_q   <= '0;
            beat_tick_q  <= 1'b0;
            tone_en_q    <= 1'b0;
            speaker_q    <= 1'b0;
            count_in_q   <= 1'b0;
            accent_q     <= 1'b0;
            half_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            eff_period_q <= eff_period_d;
            beat_num_q   <= beat_num_d;
            beat_tick_q  <= beat_tick_d;
            tone_en_q    <= tone_en_d;
            speaker_q    <= speaker_d;
            count_in_q   <= count_in_d;
            accent_q     <= accent_d;
            half_cnt_q   <= half_cnt_d;
        end
    end

    assign bus.beat_num    = beat_num_q;
    assign bus.beat_tick   = beat_tick_q;
    assign bus.tone_en     = tone_en_q;
    assign bus.speaker_out = speaker_q;
    assign bus.count_in    = count_in_q;

endmodule

// File: tb/tb_metronome_beat_scheduler.sv
// Scoreboard bench for metronome_beat_scheduler: expected per-clock output
// traces are queued when a run is started and compared clock by clock.
module tb_metronome_beat_scheduler;

    localparam int PERIOD_NS = 10;

`ifdef COUNT_IN_EN
    localparam bit CI = 1'b1;
`else
    localparam bit CI = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] num;
        logic       tick;
        logic       ten;
        logic       spk;
        logic       cin;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    metronome_beat_scheduler_if bus ();

    metronome_beat_scheduler #(
        .BEATS_PER_BAR (4),
        .BEEP_CYCLES   (10),
        .ACCENT_HALF   (2),
        .NORMAL_HALF   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #(PERIOD_NS / 2) clk = ~clk;

    obs_t exp_q[$];
    bit   sb_on  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t observe();
        obs_t o;
        o.num  = bus.beat_num;
        o.tick = bus.beat_tick;
        o.ten  = bus.tone_en;
        o.spk  = bus.speaker_out;
        o.cin  = bus.count_in;
        return o;
    endfunction

    // Scoreboard monitor: one expected entry per clock while a trace is active.
    always @(posedge clk) begin
        obs_t got;
        obs_t want;
        #1;
        if (sb_on) begin
            got = observe();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_trace t=%0t no expected entry left, got num=%0d tick=%b ten=%b spk=%b cin=%b",
                         $time, got.num, got.tick, got.ten, got.spk, got.cin);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL beat_trace t=%0t got num=%0d tick=%b ten=%b spk=%b cin=%b required num=%0d tick=%b ten=%b spk=%b cin=%b",
                             $time, got.num, got.tick, got.ten, got.spk, got.cin,
                             want.num, want.tick, want.ten, want.spk, want.cin);
                end
            end
        end
    end

    task automatic push_beat(input int num, input bit acc, input bit cin, input int period);
        logic [9:0] acc_pat;
        logic [9:0] nrm_pat;
        obs_t e;
        acc_pat = 10'b1100110011;
        nrm_pat = 10'b1110001110;
        for (int c = 0; c < period; c++) begin
            e.num  = 4'(num);
            e.tick = (c == 0);
            e.ten  = (c < 10);
            e.spk  = (c < 10) ? (acc ? acc_pat[9 - c] : nrm_pat[9 - c]) : 1'b0;
            e.cin  = cin;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_bar(input int period, input logic [3:0] mask, input bit first);
        bit ci_bar;
        ci_bar = first && CI;
        for (int b = 1; b <= 4; b++) begin
            push_beat(b, ci_bar ? 1'b1 : mask[b - 1], ci_bar, period);
        end
    endtask

    task automatic push_idle();
        obs_t e;
        e = '0;
        exp_q.push_back(e);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_run();
        @(negedge clk);
        bus.run = 1'b1;
        sb_on   = 1'b1;
    endtask

    task automatic stop_run();
        exp_q.delete();
        push_idle();
        bus.run = 1'b0;
        wait_clks(1);
        sb_on = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        obs_t got;
        bus.run         = 1'b0;
        bus.beat_period = 27'd40;
        bus.accent_mask = 15'h0001;
        rst = 1'b1;
        wait_clks(3);
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_state got %b required 00000000", got);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_clks(2);
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL idle_no_run got %b required 00000000", got);
        end

        // Reset hits in the middle of the first beep.
        push_bar(40, 4'b0001, 1'b1);
        start_run();
        wait_clks(5);
        sb_on = 1'b0;
        #1 rst = 1'b1;
        #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL async_reset_mid_beep got %b required 00000000", got);
        end
        exp_q.delete();
        push_bar(40, 4'b0001, 1'b1);
        @(negedge clk);
        rst   = 1'b0;
        sb_on = 1'b1;
        wait_clks(12);
        stop_run();
    endtask

    task automatic test_basic_bar();
        bus.beat_period = 27'd40;
        bus.accent_mask = 15'h0001;
        push_bar(40, 4'b0001, 1'b1);
        push_bar(40, 4'b0001, 1'b0);
        start_run();
        wait_clks(170);
        stop_run();
    endtask

    task automatic test_period_clamp();
        bus.beat_period = 27'd5;
        bus.accent_mask = 15'h0005;
        push_bar(12, 4'b0101, 1'b1);
        push_bar(12, 4'b0101, 1'b0);
        start_run();
        wait_clks(96);
        stop_run();
    endtask

    task automatic test_period_change();
        bus.beat_period = 27'd40;
        bus.accent_mask = 15'h0009;
        push_bar(40, 4'b1001, 1'b1);
        push_bar(20, 4'b1001, 1'b0);
        start_run();
        wait_clks(50);
        bus.beat_period = 27'd20;
        wait_clks(190);
        stop_run();
    endtask

    task automatic test_abort_restart();
        obs_t got;
        bus.beat_period = 27'd40;
        bus.accent_mask = 15'h0002;
        push_bar(40, 4'b0010, 1'b1);
        start_run();
        wait_clks(86);
        exp_q.delete();
        push_idle();
        push_bar(40, 4'b0010, 1'b1);
        bus.run = 1'b0;
        wait_clks(1);
        got = observe();
        checks++;
        if (got.num !== 4'd0 || got.ten !== 1'b0 || got.spk !== 1'b0) begin
            errors++;
            $display("FAIL abort_clears got num=%0d ten=%b spk=%b required num=0 ten=0 spk=0",
                     got.num, got.ten, got.spk);
        end
        bus.run = 1'b1;
        wait_clks(45);
        stop_run();
    endtask

    task automatic test_count_in();
        bus.beat_period = 27'd12;
        bus.accent_mask = 15'h0000;
        push_bar(12, 4'b0000, 1'b1);
        push_bar(12, 4'b0000, 1'b0);
        start_run();
        wait_clks(96);
        stop_run();
    endtask

    task automatic test_back_to_back();
        bus.beat_period = 27'd15;
        bus.accent_mask = 15'h000C;
        push_bar(15, 4'b1100, 1'b1);
        start_run();
        wait_clks(30);
        // run low for a single clock: one IDLE clock then a fresh bar.
        exp_q.delete();
        push_idle();
        push_bar(15, 4'b1100, 1'b1);
        bus.run = 1'b0;
        wait_clks(1);
        bus.run = 1'b1;
        wait_clks(60);
        stop_run();
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_bar();
        test_period_clamp();
        test_period_change();
        test_abort_restart();
        test_count_in();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
